// File: rtl/instr_encoder_if.sv
// Interface between the field source (loader) and the instruction-memory write port of instr_encoder.
// The master side drives field tuples and out_ready; the slave side (the encoder) accepts tuples and issues writes.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       jaddr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_data;

  modport master (
    output in_valid, fmt, opcode, rs, rt, shamt, funct, imm, jaddr, out_ready,
    input  in_ready, out_valid, out_addr, out_data
  );

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, shamt, funct, imm, jaddr, out_ready,
    output in_ready, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs miniRISC instruction fields into 32-bit words and writes a burst of len words to
// consecutive imem addresses through a registered valid/ready output stage.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              err,
  instr_encoder_if.slave    bus
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        in_ready;
  logic        accept;
  logic        wr_hs;

  // Bits not owned by the selected format stay zero; other formats' fields are ignored.
  always_comb begin
    enc_word        = '0;
    enc_word[31:26] = bus.opcode;
    case (bus.fmt)
      2'd0: begin
        enc_word[25:21] = bus.rs;
        enc_word[20:16] = bus.rt;
        enc_word[15:11] = bus.shamt;
        enc_word[5:0]   = bus.funct;
      end
      2'd1: begin
        enc_word[25:21] = bus.rs;
        enc_word[20:16] = bus.rt;
        enc_word[15:0]  = bus.imm;
      end
      2'd2: begin
        enc_word[25:21] = bus.rs;
        enc_word[20:0]  = bus.jaddr[20:0];
      end
      default: begin
        enc_word[25:0]  = bus.jaddr;
      end
    endcase
  end

  // A new tuple may enter whenever the output register is empty or draining this cycle.
  assign in_ready = (state_q == LOAD) && (acc_cnt_q < len_q) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign wr_hs    = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    next_addr_d = next_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d       = len;
          acc_cnt_d   = '0;
          wr_cnt_d    = '0;
          next_addr_d = BASE;
          err_d       = 1'b0;
          state_d     = (len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (wr_hs) begin
          wr_cnt_d    = wr_cnt_q + ADDR_W'(1);
          out_valid_d = 1'b0;
          if (wr_cnt_q == len_q - ADDR_W'(1)) begin
            state_d = DONE;
          end
        end
        if (accept) begin
          out_valid_d = 1'b1;
          out_addr_d  = next_addr_q;
          out_data_d  = enc_word;
          next_addr_d = next_addr_q + ADDR_W'(1);
          acc_cnt_d   = acc_cnt_q + ADDR_W'(1);
          if (bus.fmt == 2'd2 && bus.jaddr[25:21] != 5'd0) begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      next_addr_q <= BASE;
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      next_addr_q <= next_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign err           = err_q;
endmodule
